// File: rtl/thr2pry_pkg.sv
// Shared types and geometry helpers for the pipelined thermometer-to-priority decoder.
package thr2pry_pkg;

    localparam int IDX_MAX_W = 16;

    typedef struct packed {
        logic                 any;
        logic                 all;
        logic                 err;
        logic [IDX_MAX_W-1:0] idx;
    } node_t;

    function automatic int calc_levels(input int width, input int split);
        longint p;
        int     l;
        p = 1;
        l = 0;
        if (split < 2) return 1;
        for (int i = 0; i < 64; i++) begin
            if (p < longint'(width)) begin
                p = p * longint'(split);
                l++;
            end
        end
        return l;
    endfunction

    // True only when width is an exact, non-trivial power of split.
    function automatic bit geometry_ok(input int width, input int split);
        longint p;
        p = 1;
        if (split < 2 || width < split) return 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (p < longint'(width)) p = p * longint'(split);
        end
        return p == longint'(width);
    endfunction

endpackage

// File: rtl/thr2pry_node.sv
// Combinational SPLIT-to-1 merge of child node summaries for one tree level.
module thr2pry_node
    import thr2pry_pkg::*;
#(
    parameter int    SPLIT     = 2,
    parameter int    LEVEL     = 0,
    parameter string DIRECTION = "LSB"
) (
    input  node_t child_i [SPLIT],
    output node_t node_o
);

    localparam int SPAN    = SPLIT ** LEVEL;
    localparam bit MSB_DIR = (DIRECTION == "MSB");

    int   win;
    logic found;

    // Winner is the child holding the edge: lowest with any for LSB, highest for MSB.
    always_comb begin
        win   = 0;
        found = 1'b0;
        for (int c = 0; c < SPLIT; c++) begin
            if (!found && child_i[MSB_DIR ? SPLIT - 1 - c : c].any) begin
                win   = MSB_DIR ? SPLIT - 1 - c : c;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        node_o     = '0;
        node_o.any = found;
        node_o.all = 1'b1;
        for (int c = 0; c < SPLIT; c++) begin
            node_o.all = node_o.all & child_i[c].all;
            if (child_i[c].err) node_o.err = 1'b1;
            // Children on the ones side of the winner must be saturated.
            if (found && !child_i[c].all && (MSB_DIR ? (c < win) : (c > win)))
                node_o.err = 1'b1;
            if (found && c == win)
                node_o.idx = IDX_MAX_W'(win * SPAN) + child_i[c].idx;
        end
    end

endmodule

// File: rtl/thr2pry_pipe.sv
// Pipelined thermometer-to-priority decoder: one tree level per register stage,
// valid/ready at both ends with combinational ready and bubble collapsing.
module thr2pry_pipe
    import thr2pry_pkg::*;
#(
    parameter int    WIDTH     = 32,
    parameter int    SPLIT     = 2,
    parameter string DIRECTION = "LSB"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_vld,
    output logic                     s_rdy,
    input  logic [WIDTH-1:0]         thr,
    output logic                     m_vld,
    input  logic                     m_rdy,
    output logic [WIDTH-1:0]         pry,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     vld,
    output logic                     err
);

    localparam int LEVELS = calc_levels(WIDTH, SPLIT);
    localparam int IW     = $clog2(WIDTH);

    if (!geometry_ok(WIDTH, SPLIT)) begin : g_geom_bad
        $error("thr2pry_pipe: WIDTH must equal SPLIT**LEVELS with SPLIT >= 2 and LEVELS >= 1");
    end
    if (DIRECTION != "LSB" && DIRECTION != "MSB") begin : g_dir_bad
        $error("thr2pry_pipe: DIRECTION must be \"LSB\" or \"MSB\"");
    end
    if (IW >= IDX_MAX_W) begin : g_idx_bad
        $error("thr2pry_pipe: WIDTH too large for node index field");
    end

    logic [LEVELS:0] rdy;
    node_t           leaf [WIDTH];
    node_t           fin;
    logic            hit;
    logic            unused_fin;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            leaf[i]     = '0;
            leaf[i].any = thr[i];
            leaf[i].all = thr[i];
        end
    end

    assign rdy[LEVELS] = m_rdy;
    assign s_rdy       = rdy[0];

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NOUT = WIDTH / (SPLIT ** (k + 1));

        node_t node_d [NOUT];
        node_t node_q [NOUT];
        logic  vin;
        logic  v_d;
        logic  v_q;

        if (k == 0) begin : g_in
            assign vin = s_vld;
        end else begin : g_in
            assign vin = g_lvl[k-1].v_q;
        end

        assign rdy[k] = !v_q || rdy[k+1];
        assign v_d    = rdy[k] ? vin : v_q;

        for (genvar n = 0; n < NOUT; n++) begin : g_node
            node_t kids [SPLIT];
            for (genvar c = 0; c < SPLIT; c++) begin : g_kid
                if (k == 0) begin : g_src
                    assign kids[c] = leaf[n*SPLIT + c];
                end else begin : g_src
                    assign kids[c] = g_lvl[k-1].node_q[n*SPLIT + c];
                end
            end
            thr2pry_node #(
                .SPLIT     (SPLIT),
                .LEVEL     (k),
                .DIRECTION (DIRECTION)
            ) u_node (
                .child_i (kids),
                .node_o  (node_d[n])
            );
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) v_q <= 1'b0;
            else      v_q <= v_d;
        end

        always_ff @(posedge clk) begin
            if (rdy[k] && vin) node_q <= node_d;
        end
    end

    assign fin   = g_lvl[LEVELS-1].node_q[0];
    assign m_vld = g_lvl[LEVELS-1].v_q;

    // Data fields are masked by m_vld so nothing stale shows while empty or in reset.
    assign hit = m_vld && fin.any && !fin.err;
    assign vld = m_vld && fin.any;
    assign err = m_vld && fin.err;
    assign idx = hit ? fin.idx[IW-1:0] : '0;
    assign pry = hit ? (WIDTH'(1) << idx) : '0;

    assign unused_fin = fin.all ^ (^fin.idx[IDX_MAX_W-1:IW]);

endmodule

// File: doc/thr2pry_pipe.md
# thr2pry_pipe

Pipelined thermometer-to-priority decoder, the inverse of `pry2thr_tree`. It accepts a thermometer vector over a valid/ready stream, registers one tree level per cycle, and returns the priority one-hot, its binary index, a valid flag and a bubble error flag. It sits downstream of thermometer producers such as comparator banks and masked arbiters, where the full combinational decode tree does not meet timing.

## Interface
- `WIDTH`, 32: vector width; must equal `SPLIT**LEVELS` with `LEVELS >= 1`.
- `SPLIT`, 2: tree radix; must be 2 or greater.
- `DIRECTION`, "LSB": "LSB" or "MSB" thermometer orientation, with the same meaning as in `pry2thr_tree`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `s_vld`  input  1  input transfer valid.
- `s_rdy`  output  1  input transfer ready.
- `thr`  input  WIDTH  thermometer input.
- `m_vld`  output  1  output transfer valid.
- `m_rdy`  input  1  output transfer ready.
- `pry`  output  WIDTH  priority one-hot.
- `idx`  output  $clog2(WIDTH)  binary index of the priority bit.
- `vld`  output  1  the input contained at least one set bit.
- `err`  output  1  the input was not a legal thermometer.

## Operation
- Legal thermometer, "LSB": `thr[i] -> thr[i+1]` for all i. The ones run from the edge p up to the MSB. Edge p is the lowest set bit.
- Legal thermometer, "MSB": `thr[i+1] -> thr[i]`. The ones run from the LSB up to p. Edge p is the highest set bit.
- `vld = |thr`.
- `err` = 1 when any adjacent pair violates the implication for the selected direction.
- If `vld && !err`: `idx = p` and `pry = 1 << p`.
- Otherwise `idx = 0` and `pry = 0`.
- All-zero input gives `vld=0`, `err=0`. All-ones input gives `idx = 0` for "LSB" and `idx = WIDTH-1` for "MSB".
- Tree construction:
  - Level 0 splits `thr` into `WIDTH/SPLIT` groups of `SPLIT` bits.
  - Every node reports `any`, `all`, `err` and a local `idx`.
  - Combining rule for "LSB": the winner is the lowest child with `any`. `idx = {winner, child idx}`.
  - A node sets `err` if any child has `err`, or if any child above the winner does not have `all`.
  - "MSB" applies the mirrored rule.
- Final `pry` is decoded combinationally from the last-stage registered `idx`, `vld` and `err`.

## Timing
- Latency is `LEVELS` cycles from an accepted input to `m_vld`. For `WIDTH=8`, `SPLIT=2` this is 3 cycles.
- Each pipeline stage k holds a `v[k]` flag. Stage k advances when `rdy[k] = !v[k] || rdy[k+1]`. The last stage uses `rdy = !m_vld || m_rdy`.
- `s_rdy = rdy[0]`. Ready is combinational from `m_rdy`, and bubbles collapse.
- Full throughput is 1 vector per cycle while `m_rdy=1`.
- While `m_vld && !m_rdy`, the outputs `pry`, `idx`, `vld` and `err` hold stable.
- Transfers happen only on `vld && rdy` at a clock edge. Data is ignored while valid is low.
- Reset asserted: all `v[k]` clear immediately, so `m_vld=0` and `s_rdy=1`.
- Reset values of the data outputs: `pry=0`, `idx=0`, `vld=0`, `err=0`.
- Reset asserted mid-operation drops all in-flight vectors. No partial output is ever presented.
- Simultaneous accept at the input and emit at the output in the same cycle is legal, with no stall.

## Structure
- Shared package `thr2pry_pkg` holds:
  - the node result struct typedef (`any`, `all`, `err`, `idx`);
  - the function computing `LEVELS` from `WIDTH` and `SPLIT`;
  - the elaboration assertion for `WIDTH == SPLIT**LEVELS`.
- One sub-module, `thr2pry_node`: a combinational SPLIT-to-1 merge of node structs.
  - Parameterized by level and `DIRECTION`.
  - Instantiated per node inside a generate loop over levels.
  - The `v[k]` pipeline registers surround the node loop in the top module.

## Test plan
- LSB, W=8, S=2: `thr=8'b1111_1000`, `m_rdy=1` -> 3 cycles later `m_vld=1`, `idx=3`, `pry=8'b0000_1000`, `vld=1`, `err=0`.
- LSB edge cases: `thr=8'h00` -> `vld=0`, `err=0`, `idx=0`, `pry=0`. `thr=8'hFF` -> `idx=0`, `pry=8'h01`, `vld=1`.
- Bubble detection: `thr=8'b1110_1000` -> `err=1`, `vld=1`, `idx=0`, `pry=0`. `thr=8'b0111_1000` (LSB) -> `err=1`.
- MSB, W=16, S=4: `thr=16'h001F` -> latency 2, `idx=4`, `pry=16'h0010`. `thr=16'h00F1` -> `err=1`.
- Backpressure: stream 6 vectors back-to-back, holding `m_rdy=0` for cycles 4-7.
  - `s_rdy` falls once the 3 stages are full.
  - Outputs hold stable while stalled.
  - All 6 results emerge in order with none lost or duplicated.
- Reset mid-stream: assert `rst=0` with 3 vectors in flight.
  - `m_vld` drops to 0 asynchronously.
  - After release, the first new input appears exactly 3 cycles after acceptance.
